pmu_pwr_ctl_seq: RTL and testbench

Post-boot power-control sequencer downstream of the power-up sequencer. It arms when the power-up flow signals done, then watches the CPU power-control pins (PWR_CTR[1:0]) and, optionally, a front-panel power button. It executes either a reboot (FT_POR/PCIe-reset pulse) or an orderly reverse-order rail shutdown. Its active-high hold outputs are ANDed at top level with the matching power-up sequencer outputs.

---
 rtl/pmu_pkg.sv | 63 ++++++
 rtl/pmu_sync_filt.sv | 68 ++++++
 rtl/pmu_pwr_ctl_seq.sv | 152 +++++++++++++++
 tb/tb_pmu_pwr_ctl_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared definitions for the post-boot power-control sequencer.
//   - FSM state encodings and CPU power-control command codes
//   - default delay constants (STEP_DLY, POR_LOW_CYC), 25 MHz cycles
//   - hold-output bundle and the state -> hold mapping
package pmu_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CMD_W   = 2;

    localparam int unsigned PMU_FILT_CYC     = 16;
    localparam int unsigned PMU_STEP_DLY     = 501;
    localparam int unsigned PMU_POR_LOW_CYC  = 2500;
    localparam int unsigned PMU_BTN_HOLD_CYC = 100000000;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_DONE    = 4'd0,
        S_MONITOR      = 4'd1,
        S_REBOOT_POR   = 4'd2,
        S_REBOOT_REARM = 4'd3,
        S_OFF_POR      = 4'd4,
        S_OFF_18V      = 4'd5,
        S_OFF_08V      = 4'd6,
        S_OFF_VTT      = 4'd7,
        S_OFF_CLK      = 4'd8,
        S_OFF_ATX      = 4'd9,
        S_HALT         = 4'd10
    } pmu_state_e;

    typedef enum logic [CMD_W-1:0] {
        CMD_IDLE     = 2'b00,
        CMD_REBOOT   = 2'b01,
        CMD_SHUTDOWN = 2'b10,
        CMD_RSVD     = 2'b11
    } pmu_cmd_e;

    // Active-high hold gates, one per controlled group.
    typedef struct packed {
        logic atx;
        logic clk;
        logic vtt;
        logic v08;
        logic v18;
        logic por;
    } pmu_hold_t;

    // Holds implied by a state; rails dropped by earlier power-down steps stay dropped.
    // HALT and illegal encodings release nothing (all gates low).
    function automatic pmu_hold_t hold_for_state(input pmu_state_e s);
        pmu_hold_t h;
        h = '1;
        case (s)
            S_WAIT_DONE, S_MONITOR, S_REBOOT_REARM: h = '1;
            S_REBOOT_POR, S_OFF_POR:                h.por = 1'b0;
            S_OFF_18V: {h.v18, h.por} = '0;
            S_OFF_08V: {h.v08, h.v18, h.por} = '0;
            S_OFF_VTT: {h.vtt, h.v08, h.v18, h.por} = '0;
            S_OFF_CLK: {h.clk, h.vtt, h.v08, h.v18, h.por} = '0;
            default:   h = '0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/pmu_sync_filt.sv
// 2-FF synchroniser followed by a stability filter.
// The filtered output takes a new value only after the synchronised value has
// been unchanged (and different from the current output) for FILT_CYC cycles.
//   clk_i, reset_n_i : clock, async active-low reset (output loads RST_VAL)
//   async_i          : asynchronous input
//   filt_o           : synchronised, filtered value
module pmu_sync_filt
    import pmu_pkg::*;
#(
    parameter int unsigned     WIDTH    = 1,
    parameter int unsigned     FILT_CYC = PMU_FILT_CYC,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] filt_o
);

    localparam int unsigned CNT_W = $clog2(FILT_CYC + 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run_c;

    // Count consecutive cycles the synchronised value differs from the output
    // without changing itself; a change restarts the run at one.
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        run_c   = CNT_W'(1);
        if (sync2_q != filt_q) begin
            if (sync2_q == prev_q) begin
                run_c = cnt_q + CNT_W'(1);
            end
            if (run_c >= CNT_W'(FILT_CYC)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = run_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            prev_q  <= RST_VAL;
            filt_q  <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pmu_pwr_ctl_seq.sv
// Post-boot power-control sequencer: after the power-up flow completes it
// watches the CPU PWR_CTR pins (and optionally a power button) and performs a
// reboot POR pulse or a reverse-order rail shutdown. Hold outputs are
// active-high and ANDed externally with the power-up sequencer's outputs.
// Optional feature macro: PMU_PWRBTN_EN (front-panel button shutdown path).
//   clk_i, reset_n_i  : 25 MHz clock, async active-low reset
//   pwr_flow_done_i   : power-up flow complete (synchronous)
//   pwr_ctr_i[1:0]    : CPU power-control request (asynchronous)
//   pwr_btn_n_i       : front-panel button, active-low (asynchronous)
//   *_hold_o          : gates for POR, 1.8 V, 0.8 V, VTT group, clocks, ATX
//   halted_o          : shutdown complete
//   state_o[3:0]      : current FSM state
module pmu_pwr_ctl_seq
    import pmu_pkg::*;
#(
    parameter int unsigned FILT_CYC     = PMU_FILT_CYC,
    parameter int unsigned STEP_DLY     = PMU_STEP_DLY,
    parameter int unsigned POR_LOW_CYC  = PMU_POR_LOW_CYC,
    parameter int unsigned BTN_HOLD_CYC = PMU_BTN_HOLD_CYC
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               pwr_flow_done_i,
    input  logic [CMD_W-1:0]   pwr_ctr_i,
    input  logic               pwr_btn_n_i,
    output logic               por_hold_o,
    output logic               v18_hold_o,
    output logic               v08_hold_o,
    output logic               vtt_hold_o,
    output logic               clk_hold_o,
    output logic               atx_hold_o,
    output logic               halted_o,
    output logic [STATE_W-1:0] state_o
);

    pmu_state_e       state_q, state_d;
    logic [31:0]      step_cnt_q, step_cnt_d;
    pmu_hold_t        hold_q, hold_d;
    logic             halted_q, halted_d;
    logic [CMD_W-1:0] cmd_filt;
    logic             btn_req_c;
    logic             step_done_c;

    pmu_sync_filt #(
        .WIDTH    (CMD_W),
        .FILT_CYC (FILT_CYC),
        .RST_VAL  (CMD_IDLE)
    ) u_ctr_filt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (pwr_ctr_i),
        .filt_o    (cmd_filt)
    );

`ifdef PMU_PWRBTN_EN
    logic        btn_filt;
    logic [31:0] btn_cnt_q, btn_cnt_d;

    pmu_sync_filt #(
        .WIDTH    (1),
        .FILT_CYC (FILT_CYC),
        .RST_VAL  (1'b1)
    ) u_btn_filt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (pwr_btn_n_i),
        .filt_o    (btn_filt)
    );

    // Press must stay low for BTN_HOLD_CYC consecutive monitored cycles.
    always_comb begin
        btn_cnt_d = '0;
        btn_req_c = 1'b0;
        if (state_q == S_MONITOR && !btn_filt) begin
            btn_req_c = (btn_cnt_q == 32'(BTN_HOLD_CYC - 1));
            btn_cnt_d = btn_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            btn_cnt_q <= '0;
        end else begin
            btn_cnt_q <= btn_cnt_d;
        end
    end
`else
    logic unused_btn;
    assign unused_btn = ^{pwr_btn_n_i, BTN_HOLD_CYC};
    assign btn_req_c  = 1'b0;
`endif

    assign step_done_c = (step_cnt_q == 32'(STEP_DLY - 1));

    // Next state; shutdown has priority over reboot and cannot be aborted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_DONE: begin
                if (pwr_flow_done_i) state_d = S_MONITOR;
            end
            S_MONITOR: begin
                if (cmd_filt == CMD_SHUTDOWN || btn_req_c) state_d = S_OFF_POR;
                else if (cmd_filt == CMD_REBOOT)           state_d = S_REBOOT_POR;
            end
            S_REBOOT_POR: begin
                if (step_cnt_q == 32'(POR_LOW_CYC - 1)) state_d = S_REBOOT_REARM;
            end
            S_REBOOT_REARM: begin
                if (cmd_filt == CMD_SHUTDOWN)  state_d = S_OFF_POR;
                else if (cmd_filt == CMD_IDLE) state_d = S_MONITOR;
            end
            S_OFF_POR: if (step_done_c) state_d = S_OFF_18V;
            S_OFF_18V: if (step_done_c) state_d = S_OFF_08V;
            S_OFF_08V: if (step_done_c) state_d = S_OFF_VTT;
            S_OFF_VTT: if (step_done_c) state_d = S_OFF_CLK;
            S_OFF_CLK: if (step_done_c) state_d = S_OFF_ATX;
            S_OFF_ATX: if (step_done_c) state_d = S_HALT;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase

        step_cnt_d = (state_d != state_q) ? 32'd0 : step_cnt_q + 32'd1;
        // Outputs follow the current state, so they change one cycle after entry.
        hold_d     = hold_for_state(state_q);
        halted_d   = (state_q == S_HALT);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_WAIT_DONE;
            step_cnt_q <= '0;
            hold_q     <= '1;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            hold_q     <= hold_d;
            halted_q   <= halted_d;
        end
    end

    assign por_hold_o = hold_q.por;
    assign v18_hold_o = hold_q.v18;
    assign v08_hold_o = hold_q.v08;
    assign vtt_hold_o = hold_q.vtt;
    assign clk_hold_o = hold_q.clk;
    assign atx_hold_o = hold_q.atx;
    assign halted_o   = halted_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pmu_pwr_ctl_seq.sv
// Bench for pmu_pwr_ctl_seq: randomized stimulus compared every cycle against
// a time-based behavioural model, plus targeted latency/duration checks.
module tb_pmu_pwr_ctl_seq;

    localparam int F    = 16;
    localparam int STEP = 501;
    localparam int POR  = 2500;
    localparam int BTN  = 1000;

    localparam int M_WAIT  = 0;
    localparam int M_MON   = 1;
    localparam int M_RBT   = 2;
    localparam int M_REARM = 3;
    localparam int M_SHUT  = 4;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       done;
    logic [1:0] ctr;
    logic       btn_n;
    logic       por_hold_o, v18_hold_o, v08_hold_o, vtt_hold_o, clk_hold_o, atx_hold_o;
    logic       halted_o;
    logic [3:0] state_o;
    logic [5:0] holds_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    pmu_pwr_ctl_seq #(
        .FILT_CYC     (F),
        .STEP_DLY     (STEP),
        .POR_LOW_CYC  (POR),
        .BTN_HOLD_CYC (BTN)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .pwr_flow_done_i (done),
        .pwr_ctr_i       (ctr),
        .pwr_btn_n_i     (btn_n),
        .por_hold_o      (por_hold_o),
        .v18_hold_o      (v18_hold_o),
        .v08_hold_o      (v08_hold_o),
        .vtt_hold_o      (vtt_hold_o),
        .clk_hold_o      (clk_hold_o),
        .atx_hold_o      (atx_hold_o),
        .halted_o        (halted_o),
        .state_o         (state_o)
    );

    assign holds_c = {atx_hold_o, clk_hold_o, vtt_hold_o, v08_hold_o, v18_hold_o, por_hold_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc, t0;
    int         m_mode, m_state, m_prev;
    int         btn_run;
    logic [1:0] ctr_pipe[$];
    logic [1:0] ctr_win[$];
    logic [1:0] f_ctr;
    logic       btn_pipe[$];
    logic       btn_win[$];
    logic       f_btn;

    // Gates expected while the design sits in state s (bit order atx..por).
    function automatic logic [5:0] exp_holds(input int s);
        logic [5:0] h;
        h = {s < 9, s < 8, s < 7, s < 6, s < 5, !(s == 2 || s >= 4)};
        return h;
    endfunction

    function automatic void model_reset();
        cyc     = 0;
        t0      = 0;
        m_mode  = M_WAIT;
        m_state = 0;
        m_prev  = 0;
        btn_run = 0;
        ctr_pipe = '{2'b00, 2'b00};
        ctr_win.delete();
        f_ctr    = 2'b00;
        btn_pipe = '{1'b1, 1'b1};
        btn_win.delete();
        f_btn    = 1'b1;
    endfunction

    // One clock edge: decide using the filtered values held before this edge,
    // then advance the input filters by one sample.
    function automatic void model_step();
        logic [1:0] seen;
        logic       bseen;
        bit         same;
        bit         btn_req;
        int         steps;
        m_prev = m_state;
        cyc++;
        btn_req = 1'b0;
`ifdef PMU_PWRBTN_EN
        if (m_mode == M_MON && f_btn == 1'b0) begin
            btn_run++;
            btn_req = (btn_run >= BTN);
        end else begin
            btn_run = 0;
        end
`endif
        case (m_mode)
            M_WAIT: if (done) m_mode = M_MON;
            M_MON: begin
                if (f_ctr == 2'b10 || btn_req) begin m_mode = M_SHUT; t0 = cyc; end
                else if (f_ctr == 2'b01)        begin m_mode = M_RBT;  t0 = cyc; end
            end
            M_RBT: if (cyc - t0 == POR) m_mode = M_REARM;
            M_REARM: begin
                if (f_ctr == 2'b10)      begin m_mode = M_SHUT; t0 = cyc; end
                else if (f_ctr == 2'b00) m_mode = M_MON;
            end
            default: ;
        endcase
        if (m_mode == M_SHUT) begin
            steps   = (cyc - t0) / STEP;
            m_state = 4 + ((steps > 6) ? 6 : steps);
        end else begin
            m_state = m_mode;
        end

        ctr_pipe.push_back(ctr);
        seen = ctr_pipe.pop_front();
        ctr_win.push_back(seen);
        if (ctr_win.size() > F) void'(ctr_win.pop_front());
        same = (ctr_win.size() == F);
        foreach (ctr_win[i]) if (ctr_win[i] !== seen) same = 1'b0;
        if (same && seen !== f_ctr) f_ctr = seen;

        btn_pipe.push_back(btn_n);
        bseen = btn_pipe.pop_front();
        btn_win.push_back(bseen);
        if (btn_win.size() > F) void'(btn_win.pop_front());
        same = (btn_win.size() == F);
        foreach (btn_win[i]) if (btn_win[i] !== bseen) same = 1'b0;
        if (same && bseen !== f_btn) f_btn = bseen;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        chk("state",  32'(state_o),  32'(m_state));
        chk("holds",  32'(holds_c),  32'(exp_holds(m_prev)));
        chk("halted", 32'(halted_o), 32'(m_prev == 10));
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output int n);
        n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        if (state_o !== s) chk("wait_timeout", 32'(state_o), 32'(s));
    endtask

    // Assert reset between edges, check outputs at once, release after two edges.
    task automatic async_reset();
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("rst_holds",  32'(holds_c),  32'h3f);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_state",  32'(state_o),  32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        model_reset();
        ctr       = 2'b00;
        done      = 1'b0;
        btn_n     = 1'b1;
        reset_n_i = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int n;
        int lo;
        reset_n_i = 1'b1;
        ctr       = 2'b00;
        done      = 1'b0;
        btn_n     = 1'b1;
        model_reset();
        async_reset();

        // Shutdown requested before the power-up flow is done is held off.
        ctr = 2'b10;
        repeat (20 + $urandom_range(40)) tick();
        chk("gate_state", 32'(state_o), 32'd0);
        done = 1'b1;
        wait_state(4'd4, 10, n);
        chk("gate_to_off", 32'(n), 32'd2);
        wait_state(4'd10, 4000, n);
        chk("shut_len", 32'(n), 32'd3006);
        repeat (5) tick();
        chk("halt_sticky", 32'(halted_o), 32'd1);
        async_reset();

        // Reboot: one POR pulse, then rearm only once idle is accepted.
        done = 1'b1;
        repeat (3 + $urandom_range(10)) tick();
        ctr = 2'b01;
        wait_state(4'd2, 40, n);
        chk("cmd_lat", 32'(n), 32'd19);
        lo = 0;
        repeat (2600 + $urandom_range(300)) begin
            tick();
            if (!por_hold_o) lo++;
        end
        chk("por_low_len", 32'(lo), 32'd2500);
        chk("rearm_hold", 32'(state_o), 32'd3);
        ctr = 2'b00;
        wait_state(4'd1, 40, n);
        chk("rearm_lat", 32'(n), 32'd19);

        // Short pulses of any command are filtered out.
        repeat (25) begin
            ctr = 2'($urandom_range(1, 3));
            repeat ($urandom_range(1, F - 1)) tick();
            ctr = 2'b00;
            repeat ($urandom_range(1, 30)) tick();
        end
        chk("glitch_state", 32'(state_o), 32'd1);

        // Reserved code is ignored; then reboot, and shutdown from rearm.
        ctr = 2'b11;
        repeat (40 + $urandom_range(60)) tick();
        chk("rsvd_state", 32'(state_o), 32'd1);
        ctr = 2'b01;
        wait_state(4'd3, 2600, n);
        ctr = 2'b10;
        wait_state(4'd4, 40, n);
        chk("rearm_to_off", 32'(n), 32'd19);
        wait_state(4'd6, 1100, n);
        repeat ($urandom_range(1, 490)) tick();
        chk("in_08v", 32'(state_o), 32'd6);
        async_reset();
        chk("post_rst_state", 32'(state_o), 32'd0);
        repeat (5) tick();

        // Front-panel button.
        done = 1'b1;
        repeat (5) tick();
`ifdef PMU_PWRBTN_EN
        btn_n = 1'b0;
        repeat (BTN - 1) tick();
        btn_n = 1'b1;
        repeat (40) tick();
        chk("btn_short", 32'(state_o), 32'd1);
        btn_n = 1'b0;
        repeat (BTN) tick();
        btn_n = 1'b1;
        wait_state(4'd4, 40, n);
        chk("btn_long", 32'(state_o), 32'd4);
        repeat (20) tick();
`else
        btn_n = 1'b0;
        repeat (BTN + 200) tick();
        btn_n = 1'b1;
        repeat (40) tick();
        chk("btn_ignored", 32'(state_o), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
